// File: rtl/addr_generator.sv
// addr_generator
//   Upstream stage of the Decoder. Takes one key per valid/ready handshake and
//   derives K bucket addresses by double hashing, one address per cycle. The K
//   addresses are presented packed on generated_addr and held until accepted.
//   Only one key is in flight at a time.
//
// Ports
//   clk             in   1         single clock, rising edge
//   rst             in   1         synchronous, active-high reset
//   in_valid        in   1         key on data_in is valid
//   in_ready        out  1         block can accept a key (IDLE only)
//   data_in         in   DATA_W    key to hash
//   out_valid       out  1         generated_addr is complete and stable
//   out_ready       in   1         consumer accepts generated_addr
//   generated_addr  out  K*BIT     address i in bits [BIT*(i+1)-1 -: BIT]
//   busy            out  1         high while a key is being processed or held
module addr_generator #(
  parameter int SIZE   = 8,
  parameter int K      = 4,
  parameter int BIT    = $clog2(SIZE),
  parameter int DATA_W = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [K*BIT-1:0]    generated_addr,
  output logic                busy
);

  localparam int NCHUNK = DATA_W / BIT;
  localparam int CW     = (K > 1) ? $clog2(K) : 1;
  localparam logic [BIT:0]  SIZE_W = (BIT+1)'(SIZE);
  localparam logic [CW-1:0] LAST   = CW'(K - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEED,
    GEN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-1:0] key_q;
  logic [BIT-1:0]    h2_q;
  logic [BIT-1:0]    cur_q;
  logic [CW-1:0]     cnt_q;
  logic [BIT-1:0]    slots_q [K];

  logic [DATA_W-1:0] key_rev;
  logic [DATA_W-1:0] sh1, sh2;
  logic [BIT-1:0]    fold1, fold2;
  logic [BIT-1:0]    h1, h2;
  logic [BIT-1:0]    next_addr;

  // Inputs are always < 2*SIZE, so one conditional subtract reduces mod SIZE.
  function automatic logic [BIT-1:0] red(input logic [BIT:0] x);
    logic [BIT:0] r;
    r = (x >= SIZE_W) ? (x - SIZE_W) : x;
    return r[BIT-1:0];
  endfunction

  assign key_rev = {<<{key_q}};

  // Chunk folding walks the key by shifting so every select stays constant.
  always_comb begin
    fold1 = '0;
    fold2 = '0;
    sh1   = key_q;
    sh2   = key_rev;
    for (int unsigned c = 0; c < NCHUNK; c++) begin
      fold1 = fold1 ^ sh1[BIT-1:0];
      fold2 = fold2 ^ sh2[BIT-1:0];
      sh1   = sh1 >> BIT;
      sh2   = sh2 >> BIT;
    end
    h1 = red({1'b0, fold1});
    h2 = red({1'b0, fold2});
    if (h2 == '0) begin
      h2 = BIT'(1);
    end
    next_addr = red({1'b0, cur_q} + {1'b0, h2_q});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = SEED;
        end
      end
      SEED: state_nxt = GEN;
      GEN: begin
        if (cnt_q == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      h2_q    <= '0;
      cur_q   <= '0;
      cnt_q   <= '0;
      slots_q <= '{default: '0};
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key_q   <= data_in;
            slots_q <= '{default: '0};
          end
        end
        SEED: begin
          h2_q  <= h2;
          cur_q <= h1;
          cnt_q <= '0;
        end
        GEN: begin
          slots_q[cnt_q] <= cur_q;
          cur_q          <= next_addr;
          cnt_q          <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < K; i++) begin : g_pack
    assign generated_addr[i*BIT +: BIT] = slots_q[i];
  end

endmodule
